// File: rtl/excess3_to_bcd.sv
// -----------------------------------------------------------------------------
// excess3_to_bcd
//   Registered Excess-3 to BCD converter for DIGITS packed 4-bit digits.
//   Each digit lane computes BCD = XS3 - 3 independently. There is no borrow
//   between lanes. Codes outside 4'h3..4'hC are flagged in err.
//   The result is registered with one cycle of latency. out/err hold their
//   value while in_valid is low.
//
//   Parameters:
//     DIGITS     number of 4-bit digit lanes (>= 1)
//
//   Ports:
//     clk        rising-edge clock
//     rst_n      asynchronous, active-low reset
//     in_valid   in carries a word to convert this cycle
//     in         Excess-3 digits, digit k = in[4k+3:4k]
//     out_valid  out/err hold a converted word
//     out        BCD digits, digit k = out[4k+3:4k]
//     err        err[k] = 1 when input digit k was not a legal Excess-3 code
//
//   Build option:
//     EXCESS3_ZERO_INVALID_EN  when defined, an illegal digit produces 4'h0.
//                              Otherwise it produces (x - 3) mod 16.
// -----------------------------------------------------------------------------
module excess3_to_bcd #(
   parameter int unsigned DIGITS = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   input  logic [4*DIGITS-1:0]   in,
   output logic                  out_valid,
   output logic [4*DIGITS-1:0]   out,
   output logic [DIGITS-1:0]     err
);

   logic                  out_valid_d, out_valid_q;
   logic [4*DIGITS-1:0]   out_d, out_q;
   logic [DIGITS-1:0]     err_d, err_q;

   always_comb begin
      out_valid_d = in_valid;
      out_d       = out_q;
      err_d       = err_q;
      if (in_valid) begin
         for (int unsigned k = 0; k < DIGITS; k++) begin
            // 4-bit subtract wraps naturally; lanes never borrow from each other
            out_d[4*k +: 4] = in[4*k +: 4] - 4'd3;
            err_d[k]        = (in[4*k +: 4] < 4'd3) || (in[4*k +: 4] > 4'd12);
`ifdef EXCESS3_ZERO_INVALID_EN
            if (err_d[k]) begin
               out_d[4*k +: 4] = 4'h0;
            end
`endif
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid_q <= 1'b0;
         out_q       <= '0;
         err_q       <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         err_q       <= err_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out       = out_q;
   assign err       = err_q;

endmodule

// File: tb/tb_excess3_to_bcd.sv
// -----------------------------------------------------------------------------
// tb_excess3_to_bcd
//   Self-checking bench for excess3_to_bcd. It uses one DIGITS=1 instance and
//   one DIGITS=3 instance that share the clock and the reset.
// -----------------------------------------------------------------------------
module tb_excess3_to_bcd;

`ifdef EXCESS3_ZERO_INVALID_EN
   localparam bit ZERO_ILLEGAL = 1'b1;
`else
   localparam bit ZERO_ILLEGAL = 1'b0;
`endif

   logic        clk;
   logic        rst_n;

   logic        in_valid1;
   logic [3:0]  in1;
   logic        out_valid1;
   logic [3:0]  out1;
   logic [0:0]  err1;

   logic        in_valid3;
   logic [11:0] in3;
   logic        out_valid3;
   logic [11:0] out3;
   logic [2:0]  err3;

   int n_vec;
   int n_bad;

   excess3_to_bcd #(.DIGITS(1)) u_dut1 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid1),
      .in        (in1),
      .out_valid (out_valid1),
      .out       (out1),
      .err       (err1)
   );

   excess3_to_bcd #(.DIGITS(3)) u_dut3 (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid3),
      .in        (in3),
      .out_valid (out_valid3),
      .out       (out3),
      .err       (err3)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic       vld;
      logic [3:0] din;
      logic       exp_vld;
      logic [3:0] exp_out;
      logic       exp_err;
   } vec_t;

   vec_t tbl [18];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference: a digit value v is legal in 3..12 and maps to v-3.
   // An illegal value maps to (v-3) mod 16, or to 0 in the zeroing build.
   function automatic int ref_digit(input int v);
      if (v >= 3 && v <= 12) return v - 3;
      if (ZERO_ILLEGAL)      return 0;
      return (v + 13) % 16;
   endfunction

   function automatic bit ref_illegal(input int v);
      return !(v >= 3 && v <= 12);
   endfunction

   // Drive one cycle of inputs on the falling edge, then sample just after
   // the rising edge that captures them.
   task automatic cycle1(input logic v, input logic [3:0] d);
      @(negedge clk);
      in_valid1 = v;
      in1       = d;
      @(posedge clk);
      #1;
   endtask

   task automatic cycle3(input logic v, input logic [11:0] d);
      @(negedge clk);
      in_valid3 = v;
      in3       = d;
      @(posedge clk);
      #1;
   endtask

   logic        m_vld1, m_vld3;
   logic [3:0]  m_out1;
   logic [0:0]  m_err1;
   logic [11:0] m_out3;
   logic [2:0]  m_err3;
   logic [3:0]  a_in1;
   logic [11:0] a_in3;
   logic        a_v1, a_v3;

   initial begin
      n_vec     = 0;
      n_bad     = 0;
      in_valid1 = 1'b0;
      in1       = '0;
      in_valid3 = 1'b0;
      in3       = '0;

      // Sweep of all 16 codes, then the hold case
      tbl[0]  = '{1'b1, 4'h0, 1'b1, ZERO_ILLEGAL ? 4'h0 : 4'hD, 1'b1};
      tbl[1]  = '{1'b1, 4'h1, 1'b1, ZERO_ILLEGAL ? 4'h0 : 4'hE, 1'b1};
      tbl[2]  = '{1'b1, 4'h2, 1'b1, ZERO_ILLEGAL ? 4'h0 : 4'hF, 1'b1};
      tbl[3]  = '{1'b1, 4'h3, 1'b1, 4'h0, 1'b0};
      tbl[4]  = '{1'b1, 4'h4, 1'b1, 4'h1, 1'b0};
      tbl[5]  = '{1'b1, 4'h5, 1'b1, 4'h2, 1'b0};
      tbl[6]  = '{1'b1, 4'h6, 1'b1, 4'h3, 1'b0};
      tbl[7]  = '{1'b1, 4'h7, 1'b1, 4'h4, 1'b0};
      tbl[8]  = '{1'b1, 4'h8, 1'b1, 4'h5, 1'b0};
      tbl[9]  = '{1'b1, 4'h9, 1'b1, 4'h6, 1'b0};
      tbl[10] = '{1'b1, 4'hA, 1'b1, 4'h7, 1'b0};
      tbl[11] = '{1'b1, 4'hB, 1'b1, 4'h8, 1'b0};
      tbl[12] = '{1'b1, 4'hC, 1'b1, 4'h9, 1'b0};
      tbl[13] = '{1'b1, 4'hD, 1'b1, ZERO_ILLEGAL ? 4'h0 : 4'hA, 1'b1};
      tbl[14] = '{1'b1, 4'hE, 1'b1, ZERO_ILLEGAL ? 4'h0 : 4'hB, 1'b1};
      tbl[15] = '{1'b1, 4'hF, 1'b1, ZERO_ILLEGAL ? 4'h0 : 4'hC, 1'b1};
      tbl[16] = '{1'b1, 4'h8, 1'b1, 4'h5, 1'b0};
      tbl[17] = '{1'b0, 4'hA, 1'b0, 4'h5, 1'b0};

      // Reset state, asserted before any clock edge
      rst_n = 1'b0;
      #3;
      chk("reset_vld1", out_valid1, 1'b0);
      chk("reset_out1", out1, 4'h0);
      chk("reset_err1", err1, 1'b0);
      chk("reset_out3", out3, 12'h000);
      chk("reset_err3", err3, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;

      // Table-driven sweep and hold on the DIGITS=1 instance
      for (int i = 0; i < 18; i++) begin
         cycle1(tbl[i].vld, tbl[i].din);
         chk($sformatf("tbl%0d_vld", i), out_valid1, tbl[i].exp_vld);
         chk($sformatf("tbl%0d_out", i), out1,       tbl[i].exp_out);
         chk($sformatf("tbl%0d_err", i), err1,       tbl[i].exp_err);
      end

      // Back-to-back words with no bubbles
      for (int i = 0; i < 3; i++) begin
         cycle1(1'b1, 4'(4 + i));
         chk($sformatf("b2b%0d_vld", i), out_valid1, 1'b1);
         chk($sformatf("b2b%0d_out", i), out1, 4'(1 + i));
      end

      // Multi-digit lanes
      cycle3(1'b1, 12'h3C6);
      chk("d3_a_vld", out_valid3, 1'b1);
      chk("d3_a_out", out3, 12'h093);
      chk("d3_a_err", err3, 3'b000);
      cycle3(1'b1, 12'h3F6);
      chk("d3_b_out", out3, ZERO_ILLEGAL ? 12'h003 : 12'h0C3);
      chk("d3_b_err", err3, 3'b010);
      cycle3(1'b0, 12'h777);
      chk("d3_hold_vld", out_valid3, 1'b0);
      chk("d3_hold_out", out3, ZERO_ILLEGAL ? 12'h003 : 12'h0C3);

      // Mid-stream reset clears the outputs at once, between clock edges
      cycle1(1'b1, 4'hF);
      cycle3(1'b1, 12'hF0F);
      #2;
      rst_n = 1'b0;
      #1;
      chk("mid_rst_vld1", out_valid1, 1'b0);
      chk("mid_rst_out1", out1, 4'h0);
      chk("mid_rst_err1", err1, 1'b0);
      chk("mid_rst_vld3", out_valid3, 1'b0);
      chk("mid_rst_out3", out3, 12'h000);
      chk("mid_rst_err3", err3, 3'b000);
      @(negedge clk);
      rst_n = 1'b1;
      in_valid1 = 1'b0;
      in_valid3 = 1'b0;
      @(posedge clk);
      #1;
      chk("post_rst_vld3", out_valid3, 1'b0);
      chk("post_rst_out3", out3, 12'h000);

      // Random words checked against the reference model. Reset first so
      // that the model's state is known.
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      rst_n  = 1'b1;
      m_vld1 = 1'b0; m_out1 = '0; m_err1 = '0;
      m_vld3 = 1'b0; m_out3 = '0; m_err3 = '0;
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         a_v1 = 1'($urandom_range(0, 3) != 0);
         a_in1 = 4'($urandom);
         a_v3 = 1'($urandom_range(0, 3) != 0);
         a_in3 = 12'($urandom);
         in_valid1 = a_v1;
         in1       = a_in1;
         in_valid3 = a_v3;
         in3       = a_in3;
         @(posedge clk);
         #1;
         m_vld1 = a_v1;
         if (a_v1) begin
            m_out1 = 4'(ref_digit(int'(a_in1)));
            m_err1 = ref_illegal(int'(a_in1));
         end
         m_vld3 = a_v3;
         if (a_v3) begin
            for (int k = 0; k < 3; k++) begin
               int v;
               v = (int'(a_in3) / (16 ** k)) % 16;
               m_out3[4*k +: 4] = 4'(ref_digit(v));
               m_err3[k]        = ref_illegal(v);
            end
         end
         chk("rnd_vld1", out_valid1, m_vld1);
         chk("rnd_out1", out1, m_out1);
         chk("rnd_err1", err1, m_err1);
         chk("rnd_vld3", out_valid3, m_vld3);
         chk("rnd_out3", out3, m_out3);
         chk("rnd_err3", err3, m_err3);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
